// File: rtl/idivide_pkg.sv
// Shared definitions for the iDivide integer divider: the datapath word
// width, the divider state encoding and the UDIV/SDIV opcode fields used by
// decode to steer instructions to the divider.
package idivide_pkg;

  // Default datapath width of the LEGv8 core.
  localparam int WORD = 64;

  // Divider sequencing states, 2-bit encoded.
  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_FIX  = 2'd2,
    DIV_DONE = 2'd3
  } div_state_e;

  // Data-processing (2 source) opcode shared by UDIV and SDIV (bits [31:21]).
  localparam logic [10:0] OPC_DIV    = 11'b10011010110;
  // Function field (bits [15:10]) selecting the divide flavour.
  localparam logic [5:0]  FUNCT_UDIV = 6'b000010;
  localparam logic [5:0]  FUNCT_SDIV = 6'b000011;

  typedef struct packed {
    logic is_div;     // instruction targets the divider
    logic is_signed;  // SDIV rather than UDIV
  } div_decode_t;

  // Classify a 32-bit instruction word for the decode stage.
  function automatic div_decode_t decode_div(input logic [31:0] insn);
    div_decode_t d;
    d.is_div    = (insn[31:21] == OPC_DIV) &&
                  ((insn[15:10] == FUNCT_UDIV) || (insn[15:10] == FUNCT_SDIV));
    d.is_signed = (insn[31:21] == OPC_DIV) && (insn[15:10] == FUNCT_SDIV);
    return d;
  endfunction

endpackage

// File: rtl/idivide_if.sv
// Request/response bundle between decode-side control and the divider.
// The master raises start with the operands; the slave (the divider)
// reports busy, pulses done and holds the results.
interface idivide_if #(
  parameter int WIDTH = 64
);
  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/idivide_div_step.sv
// One iteration of restoring division: shift the partial remainder left,
// pulling in the next dividend bit, and keep the trial difference only if
// the divisor fits. Purely combinational.
module div_step #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_next,
  output logic [WIDTH-1:0] quo_next
);

  // The shifted remainder needs WIDTH+1 bits: rem < divisor may exceed
  // 2^(WIDTH-1), so doubling it can carry out of a WIDTH-bit word.
  logic [WIDTH:0]   shifted;
  // One extra bit on top of the WIDTH+1-bit trial result acts as the borrow.
  logic [WIDTH+1:0] trial;
  logic             fits;

  assign shifted  = {rem, quo[WIDTH-1]};
  assign trial    = {1'b0, shifted} - {2'b00, divisor};
  assign fits     = ~trial[WIDTH+1];

  // When the divisor fits the difference is below divisor, and when it does
  // not the shifted value is below divisor, so WIDTH bits always suffice.
  assign rem_next = fits ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
  assign quo_next = {quo[WIDTH-2:0], fits};

endmodule

// File: rtl/idivide.sv
// iDivide: multi-cycle UDIV/SDIV execution resource. Signed operands are
// reduced to magnitudes on capture, divided one quotient bit per clock with
// div_step, then sign-corrected in FIX. Divide by zero bypasses the loop.
module idivide
  import idivide_pkg::*;
#(
  parameter int WIDTH = WORD
) (
  input logic      clk,
  input logic      reset,
  idivide_if.slave bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state, state_next;
  logic [CNT_W-1:0] count;

  // Working registers for the iteration.
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] quo_r;
  logic [WIDTH-1:0] dvsr_r;
  logic             q_neg_r;
  logic             r_neg_r;

  // Registered outputs.
  logic             busy_r;
  logic             done_r;
  logic             dbz_r;
  logic [WIDTH-1:0] quotient_r;
  logic [WIDTH-1:0] remainder_r;

  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;

  logic             accept;
  logic             zero_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  // Starts are taken only when truly idle; done_r still high means the state
  // register has already returned to IDLE during the done pulse, and that
  // cycle must not accept a new request.
  assign accept   = bus.start && (state == DIV_IDLE) && !done_r;
  assign zero_div = (bus.divisor == '0);

  // Two's complement magnitude; the most negative value maps onto itself,
  // which read as unsigned is exactly its magnitude 2^(WIDTH-1).
  assign a_neg = bus.is_signed && bus.dividend[WIDTH-1];
  assign b_neg = bus.is_signed && bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem      (rem_r),
    .quo      (quo_r),
    .divisor  (dvsr_r),
    .rem_next (rem_step),
    .quo_next (quo_step)
  );

  // State register; reset is synchronous and overrides every other event.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every
    // register samples the pre-edge values of the others.
    if (reset) state <= DIV_IDLE;
    else       state <= state_next;
  end

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_next; a missing
    // branch would otherwise infer a latch.
    state_next = state;
    unique case (state)
      DIV_IDLE: if (accept) state_next = zero_div ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (count == CNT_W'(WIDTH - 1)) state_next = DIV_FIX;
      DIV_FIX:  state_next = DIV_DONE;
      DIV_DONE: state_next = DIV_IDLE;
      default:  state_next = DIV_IDLE;
    endcase
  end

  // Operand capture, iteration and result loading.
  always_ff @(posedge clk) begin
    if (reset) begin
      count       <= '0;
      rem_r       <= '0;
      quo_r       <= '0;
      dvsr_r      <= '0;
      q_neg_r     <= 1'b0;
      r_neg_r     <= 1'b0;
      dbz_r       <= 1'b0;
      quotient_r  <= '0;
      remainder_r <= '0;
    end else begin
      unique case (state)
        DIV_IDLE: begin
          if (accept) begin
            count   <= '0;
            rem_r   <= '0;
            quo_r   <= a_mag;
            dvsr_r  <= b_mag;
            q_neg_r <= a_neg ^ b_neg;
            r_neg_r <= a_neg;
            if (zero_div) begin
              // Architectural divide-by-zero result: the raw dividend is
              // returned as the remainder, no sign handling.
              quotient_r  <= '0;
              remainder_r <= bus.dividend;
              dbz_r       <= 1'b1;
            end
          end
        end
        DIV_CALC: begin
          rem_r <= rem_step;
          quo_r <= quo_step;
          count <= count + CNT_W'(1);
        end
        DIV_FIX: begin
          // Sign flags are only ever set in signed mode. MIN / -1 wraps
          // back to MIN here without any special case.
          quotient_r  <= q_neg_r ? -quo_r : quo_r;
          remainder_r <= r_neg_r ? -rem_r : rem_r;
          dbz_r       <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Status flags lag the state by one clock, so busy spans CALC and FIX as
  // seen one cycle later and done coincides with the cycle after DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      busy_r <= (state == DIV_CALC) || (state == DIV_FIX);
      done_r <= (state == DIV_DONE);
    end
  end

  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.quotient    = quotient_r;
  assign bus.remainder   = remainder_r;
  assign bus.div_by_zero = dbz_r;

endmodule

// File: tb/tb_idivide.sv
// Self-checking bench for idivide. Expected results are pushed to a
// scoreboard queue when a request is driven and popped by a monitor when
// done pulses. A second, 8-bit instance covers the narrow configuration.
module tb_idivide;

  typedef struct {
    string       tag;
    logic [63:0] q;
    logic [63:0] r;
    logic        dbz;
    int          k;       // clock edge at which start is sampled
    int          lat;     // expected edges from start to done
    int          busy_n;  // expected number of busy cycles
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_err;
  int   busy_cnt;
  exp_t sb[$];

  idivide_if #(.WIDTH(64)) bus ();
  idivide_if #(.WIDTH(8))  bus8 ();

  idivide #(.WIDTH(64)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  idivide #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // Monitor: sample away from the rising edge, compare on every done pulse.
  always @(negedge clk) begin
    exp_t it;
    if (reset) busy_cnt = 0;
    else if (bus.busy) busy_cnt++;
    if (bus.done) begin
      if (sb.size() == 0) begin
        check("spurious_done", 64'(bus.done), 64'd0);
      end else begin
        it = sb.pop_front();
        check({it.tag, "_q"},    bus.quotient,          it.q);
        check({it.tag, "_r"},    bus.remainder,         it.r);
        check({it.tag, "_dbz"},  64'(bus.div_by_zero),  64'(it.dbz));
        check({it.tag, "_lat"},  64'(cyc - it.k),       64'(it.lat));
        check({it.tag, "_busy"}, 64'(busy_cnt),         64'(it.busy_n));
      end
      busy_cnt = 0;
    end
  end

  // Drive a one-cycle start; optionally push the expected completion.
  task automatic start_op(input string tag, input bit sgn, input logic [63:0] a,
                          input logic [63:0] b, input bit push,
                          input logic [63:0] eq, input logic [63:0] er, input bit edbz);
    exp_t it;
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    if (push) begin
      it.tag    = tag;
      it.q      = eq;
      it.r      = er;
      it.dbz    = edbz;
      it.k      = cyc + 1;
      it.lat    = (b == 64'd0) ? 1 : 66;
      it.busy_n = (b == 64'd0) ? 0 : 65;
      sb.push_back(it);
    end
    @(posedge clk); #1;
    bus.start    = 1'b0;
    bus.dividend = 64'hDEAD_BEEF_DEAD_BEEF;
    bus.divisor  = 64'h0;
  endtask

  // Returns at the falling edge inside the done cycle (bounded wait).
  task automatic wait_done(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
  endtask

  task automatic run8(input string tag, input bit sgn, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] eq,
                      input logic [7:0] er, input int elat);
    int k;
    bit seen;
    @(posedge clk); #1;
    bus8.start     = 1'b1;
    bus8.is_signed = sgn;
    bus8.dividend  = a;
    bus8.divisor   = b;
    k = cyc + 1;
    @(posedge clk); #1;
    bus8.start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (bus8.done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (seen) begin
      check({tag, "_q"},   64'(bus8.quotient),  64'(eq));
      check({tag, "_r"},   64'(bus8.remainder), 64'(er));
      check({tag, "_lat"}, 64'(cyc - k),        64'(elat));
    end
  endtask

  initial begin
    logic [63:0] a, b, eq, er;
    bit          s;
    cyc            = 0;
    n_cmp          = 0;
    n_err          = 0;
    busy_cnt       = 0;
    reset          = 1'b1;
    bus.start      = 1'b0;
    bus.is_signed  = 1'b0;
    bus.dividend   = '0;
    bus.divisor    = '0;
    bus8.start     = 1'b0;
    bus8.is_signed = 1'b0;
    bus8.dividend  = '0;
    bus8.divisor   = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    check("rst_busy", 64'(bus.busy),        64'd0);
    check("rst_done", 64'(bus.done),        64'd0);
    check("rst_dbz",  64'(bus.div_by_zero), 64'd0);
    check("rst_q",    bus.quotient,         64'd0);
    check("rst_r",    bus.remainder,        64'd0);

    // Basic unsigned, then signed sign combinations.
    start_op("u100_7", 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 64'd2, 1'b0);
    wait_done("u100_7");
    start_op("sn100_7", 1'b1, -64'sd100, 64'd7, 1'b1,
             64'hFFFF_FFFF_FFFF_FFF2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
    wait_done("sn100_7");
    start_op("s100_n7", 1'b1, 64'd100, -64'sd7, 1'b1,
             64'hFFFF_FFFF_FFFF_FFF2, 64'd2, 1'b0);
    wait_done("s100_n7");

    // Divide by zero, then a normal op clears the flag.
    start_op("u5_0", 1'b0, 64'd5, 64'd0, 1'b1, 64'd0, 64'd5, 1'b1);
    wait_done("u5_0");
    start_op("u9_3", 1'b0, 64'd9, 64'd3, 1'b1, 64'd3, 64'd0, 1'b0);
    wait_done("u9_3");
    start_op("sn5_0", 1'b1, -64'sd5, 64'd0, 1'b1, 64'd0, -64'sd5, 1'b1);
    wait_done("sn5_0");

    // Overflow and extreme operands.
    start_op("smin_n1", 1'b1, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
             64'h8000_0000_0000_0000, 64'd0, 1'b0);
    wait_done("smin_n1");
    start_op("umax_1", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b1,
             64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0);
    wait_done("umax_1");
    start_op("umax_big", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1,
             64'd1, 64'd1, 1'b0);
    wait_done("umax_big");

    // Start while busy is ignored.
    start_op("busy_ign", 1'b0, 64'd100, 64'd7, 1'b1, 64'd14, 64'd2, 1'b0);
    repeat (8) @(posedge clk);
    #1;
    bus.start    = 1'b1;
    bus.dividend = 64'd50;
    bus.divisor  = 64'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done("busy_ign");

    // Start held through the done cycle is ignored there and accepted the
    // cycle after.
    begin
      exp_t it;
      #1;
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.dividend  = 64'd50;
      bus.divisor   = 64'd5;
      it.tag    = "b2b";
      it.q      = 64'd10;
      it.r      = 64'd0;
      it.dbz    = 1'b0;
      it.k      = cyc + 2;
      it.lat    = 66;
      it.busy_n = 65;
      sb.push_back(it);
      @(posedge clk); #1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_done("b2b");
    end

    // Reset mid-operation aborts with no done pulse.
    start_op("abort", 1'b0, 64'd100, 64'd7, 1'b0, 64'd0, 64'd0, 1'b0);
    repeat (18) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check("abort_busy", 64'(bus.busy),        64'd0);
    check("abort_done", 64'(bus.done),        64'd0);
    check("abort_q",    bus.quotient,         64'd0);
    check("abort_r",    bus.remainder,        64'd0);
    check("abort_dbz",  64'(bus.div_by_zero), 64'd0);
    repeat (80) @(posedge clk);
    start_op("u81_9", 1'b0, 64'd81, 64'd9, 1'b1, 64'd9, 64'd0, 1'b0);
    wait_done("u81_9");

    // Random operands against the language's own division operators.
    for (int i = 0; i < 4; i++) begin
      s = i[0];
      a = {$urandom, $urandom};
      b = (i < 2) ? 64'($urandom_range(1, 1000)) : ({$urandom, $urandom} | 64'h1);
      if (b == 64'hFFFF_FFFF_FFFF_FFFF) b = 64'd3;
      if (s) begin
        eq = 64'($signed(a) / $signed(b));
        er = 64'($signed(a) % $signed(b));
      end else begin
        eq = a / b;
        er = a % b;
      end
      start_op($sformatf("rnd%0d", i), s, a, b, 1'b1, eq, er, 1'b0);
      wait_done($sformatf("rnd%0d", i));
    end

    // Narrow configuration.
    run8("w8_100_7",  1'b0, 8'd100, 8'd7,  8'd14,  8'd2,  10);
    run8("w8_min_n1", 1'b1, 8'h80,  8'hFF, 8'h80,  8'h00, 10);
    run8("w8_n7_2",   1'b1, 8'hF9,  8'h02, 8'hFD,  8'hFF, 10);
    run8("w8_8_0",    1'b0, 8'd8,   8'd0,  8'd0,   8'd8,  1);

    repeat (3) @(posedge clk);
    check("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/idivide.md
Name: iDivide

Overview:
- Multi-cycle hardware integer divider for the LEGv8 datapath. Replaces the software shift/subtract division loop with a UDIV/SDIV execution resource.
- Sits beside iExecute. Decode-side control raises `start` with the operands from the register file, then stalls fetch while `busy` is high.
- Computes one quotient bit per clock (restoring algorithm). Supports signed and unsigned modes, parametrised operand width.
- Divide-by-zero and signed overflow follow ARMv8 UDIV/SDIV semantics.

Parameters:
- WIDTH, 64 (`WORD): operand, quotient and remainder width in bits; legal values 8..64.
- CNT_W, $clog2(WIDTH+1): iteration counter width; derived, not overridden.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; sampled on posedge clk.
- start  input  1  request; sampled only in IDLE.
- is_signed  input  1  1 = SDIV (two's complement), 0 = UDIV; captured with start.
- dividend  input  WIDTH  numerator; captured with start.
- divisor  input  WIDTH  denominator; captured with start.
- busy  output  1  high from the cycle after an accepted start until done.
- done  output  1  single-cycle pulse; results are valid in this cycle.
- quotient  output  WIDTH  registered result; held until the next accepted start.
- remainder  output  WIDTH  registered result; held until the next accepted start.
- div_by_zero  output  1  registered flag; valid with done, held with the results.

Behaviour:
- Reset: state goes to IDLE. busy, done, div_by_zero, quotient, remainder and counter all go to 0. Reset asserted mid-operation aborts the division with no done pulse; it has priority over every other event.
- States:
  - IDLE → CALC on start && divisor != 0.
  - IDLE → DONE on start && divisor == 0.
  - CALC → CALC while count < WIDTH-1.
  - CALC → FIX when count == WIDTH-1.
  - FIX → DONE.
  - DONE → IDLE, always.
- Capture at start: latch is_signed. In signed mode, store |dividend| and |divisor|, plus q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend). Absolute value uses a WIDTH-bit two's complement negate, so MIN maps to MIN, which is treated as unsigned 2^(WIDTH-1).
- CALC step (shared sub-module):
  - Shift {rem, quo} left by one, bringing in the MSB of the working dividend.
  - Trial-subtract the divisor from rem in WIDTH+1 bits.
  - If the result is non-negative, rem takes the difference and the new quotient bit is 1; otherwise the quotient bit is 0.
  - Exactly WIDTH CALC cycles.
- FIX: in signed mode, negate the quotient if q_neg and the remainder if r_neg. Load the output registers.
- DONE: done = 1 for exactly one cycle, busy = 0 in that cycle.
- Latency:
  - Accepted start at edge k → done high in the cycle following edge k+WIDTH+2.
  - busy high from edge k+1 through edge k+WIDTH+1.
  - Zero divisor: done follows edge k+1 (busy stays 0).
- Divide by zero: quotient = 0, remainder = dividend (unmodified), div_by_zero = 1. Any other completion clears div_by_zero.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0. This falls out of the WIDTH-bit wrap and needs no special case.
- Rounding: quotient truncates toward zero; remainder takes the sign of the dividend; dividend == quotient*divisor + remainder always holds (mod 2^WIDTH).
- start while busy, or in the DONE cycle: ignored. Operand inputs are don't-care outside the start cycle.
- Back-to-back: a start in the cycle after done is accepted normally.

Decomposition:
- Shared definitions header:
  - Reuse `WORD.
  - Add `DIV_IDLE, `DIV_CALC, `DIV_FIX, `DIV_DONE as a 2-bit state encoding.
  - Add opcode constants for UDIV (11'b10011010110, bits [15:10] = 000010) and SDIV (bits [15:10] = 000011) for the decode integration.
- Sub-module div_step (combinational, parametrised WIDTH):
  - Inputs: rem, quo, divisor.
  - Outputs: next rem and next quo.
  - Instantiated once in iDivide; independently testable.

Test Plan:
- Unsigned 100 / 7 with WIDTH=64 → done exactly 66 cycles after start edge, quotient 14, remainder 2, div_by_zero 0, busy high 65 cycles.
- Signed −100 / 7, then 100 / −7 → quotient −14 (0xFFFF_FFFF_FFFF_FFF2) with remainder −2, then quotient −14 with remainder 2.
- 5 / 0 (unsigned) → done in the cycle after the start edge, quotient 0, remainder 5, div_by_zero 1, busy never high; the next 9/3 clears the flag.
- Signed 0x8000_0000_0000_0000 / −1 → quotient 0x8000_0000_0000_0000, remainder 0. Also unsigned 0xFFFF_FFFF_FFFF_FFFF / 1 → quotient all ones, remainder 0.
- Start 100/7, reassert start with 50/5 at cycle 10 → ignored; results stay 14/2. Then start 50/5 the cycle after done → quotient 10, remainder 0 after 66 cycles.
- Start 100/7, assert reset at cycle 20 → busy 0 next cycle, outputs 0, no done pulse. Then 81/9 → quotient 9, remainder 0. Repeat 100/7 with WIDTH=8 → done after 10 cycles.
